pingpong_layer_buffer: RTL and testbench

//  Double-banked (ping-pong) store for one neuron layer's outputs, sitting between layer N and layer N+1.

---
 rtl/nn_buffer_pkg.sv | 17 +
 rtl/pingpong_layer_buffer_if.sv | 32 +++
 rtl/buffer_bank.sv | 30 +++
 rtl/pingpong_layer_buffer.sv | 82 ++++++++
 tb/tb_pingpong_layer_buffer.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/nn_buffer_pkg.sv
// nn_buffer_pkg: shared types and defaults for the ping-pong layer buffer.
package nn_buffer_pkg;

    typedef enum logic {BANK_EMPTY, BANK_FULL} bank_state_e;

    localparam int DEF_DATA_W = 8;
    localparam logic [DEF_DATA_W-1:0] DEF_BIAS_VAL = 8'd127;

    function automatic int bank_depth(input int neurons, input int slots);
        return neurons * slots;
    endfunction

    function automatic int slot_w(input int slots);
        return slots > 1 ? $clog2(slots) : 1;
    endfunction

endpackage

// File: rtl/pingpong_layer_buffer_if.sv
// pingpong_layer_buffer_if: writer/reader handshake and data bus of the layer buffer.
interface pingpong_layer_buffer_if
    import nn_buffer_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NEURONS = 10,
    parameter int SLOTS   = 2,
    parameter int ADDR_W  = 7
);
    logic                      write;
    logic [slot_w(SLOTS)-1:0]  writeloc;
    logic [NEURONS*DATA_W-1:0] wdata;
    logic                      wr_commit;
    logic                      wr_ready;
    logic                      rd_en;
    logic [ADDR_W-1:0]         readloc;
    logic                      rd_release;
    logic                      rd_ready;
    logic [DATA_W-1:0]         R;
    logic                      rd_valid;
    logic                      err;

    modport master (
        output write, writeloc, wdata, wr_commit, rd_en, readloc, rd_release,
        input  wr_ready, rd_ready, R, rd_valid, err
    );

    modport slave (
        input  write, writeloc, wdata, wr_commit, rd_en, readloc, rd_release,
        output wr_ready, rd_ready, R, rd_valid, err
    );
endinterface

// File: rtl/buffer_bank.sv
// buffer_bank: one DEPTH x DATA_W bank with a NEURONS-wide group write and a combinational read.
module buffer_bank
    import nn_buffer_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NEURONS = 10,
    parameter int SLOTS   = 2,
    localparam int DEPTH  = bank_depth(NEURONS, SLOTS),
    localparam int AW     = $clog2(DEPTH),
    localparam int SW     = slot_w(SLOTS)
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [SW-1:0]             wgrp,
    input  logic [NEURONS*DATA_W-1:0] wdata,
    input  logic [AW-1:0]             raddr,
    output logic [DATA_W-1:0]         rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NEURONS; i++) begin
                mem[AW'(int'(wgrp) * NEURONS + i)] <= wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/pingpong_layer_buffer.sv
// pingpong_layer_buffer: two-bank layer output store; writer fills one bank while reader drains the other.
module pingpong_layer_buffer
    import nn_buffer_pkg::*;
#(
    parameter int DATA_W               = DEF_DATA_W,
    parameter int NEURONS              = 10,
    parameter int SLOTS                = 2,
    parameter int ADDR_W               = 7,
    parameter int BIAS_ADDR            = 62,
    parameter logic [DATA_W-1:0] BIAS_VAL = DEF_BIAS_VAL
) (
    input logic clk,
    input logic rst,
    pingpong_layer_buffer_if.slave bus
);
    localparam int DEPTH = bank_depth(NEURONS, SLOTS);
    localparam int AW    = $clog2(DEPTH);

    bank_state_e       state_q [2];
    bank_state_e       state_d [2];
    logic              wp_q, wp_d, rp_q, rp_d, rd_valid_q, rd_valid_d, err_q, err_d;
    logic [DATA_W-1:0] r_q, r_d, rdata0, rdata1;
    logic              wr_ready, rd_ready, loc_ok, wr_ok, commit_ok, rel_ok, rd_ok;

    assign wr_ready  = state_q[wp_q] == BANK_EMPTY;
    assign rd_ready  = state_q[rp_q] == BANK_FULL;
    assign loc_ok    = int'(bus.writeloc) < SLOTS;
    assign wr_ok     = bus.write & wr_ready & loc_ok;
    assign commit_ok = bus.wr_commit & wr_ready;
    assign rel_ok    = bus.rd_release & rd_ready;
    assign rd_ok     = bus.rd_en & rd_ready;

    buffer_bank #(.DATA_W(DATA_W), .NEURONS(NEURONS), .SLOTS(SLOTS)) u_bank0 (
        .clk(clk), .we(wr_ok & ~wp_q), .wgrp(bus.writeloc), .wdata(bus.wdata),
        .raddr(bus.readloc[AW-1:0]), .rdata(rdata0)
    );

    buffer_bank #(.DATA_W(DATA_W), .NEURONS(NEURONS), .SLOTS(SLOTS)) u_bank1 (
        .clk(clk), .we(wr_ok & wp_q), .wgrp(bus.writeloc), .wdata(bus.wdata),
        .raddr(bus.readloc[AW-1:0]), .rdata(rdata1)
    );

    // Commit and release never hit the same bank: one needs EMPTY, the other FULL.
    always_comb begin
        state_d = state_q;
        if (commit_ok) state_d[wp_q] = BANK_FULL;
        if (rel_ok) state_d[rp_q] = BANK_EMPTY;
        wp_d       = wp_q ^ commit_ok;
        rp_d       = rp_q ^ rel_ok;
        rd_valid_d = rd_ok;
        r_d        = !rd_ok                         ? r_q :
                     int'(bus.readloc) == BIAS_ADDR ? BIAS_VAL :
                     int'(bus.readloc) >= DEPTH     ? '0 :
                     rp_q                           ? rdata1 : rdata0;
        err_d      = err_q | (bus.write & ~(wr_ready & loc_ok)) | (bus.wr_commit & ~wr_ready)
                   | (bus.rd_release & ~rd_ready) | (bus.rd_en & ~rd_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= '{BANK_EMPTY, BANK_EMPTY};
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            r_q        <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            r_q        <= r_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    assign bus.wr_ready = wr_ready;
    assign bus.rd_ready = rd_ready;
    assign bus.R        = r_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_pingpong_layer_buffer.sv
// tb_pingpong_layer_buffer: directed checks of fill/commit/read/release handshakes and read decode.
module tb_pingpong_layer_buffer;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;

    pingpong_layer_buffer_if #(.DATA_W(8), .NEURONS(10), .SLOTS(2), .ADDR_W(7)) bus ();

    pingpong_layer_buffer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.write = 0; bus.writeloc = 0; bus.wdata = '0; bus.wr_commit = 0;
        bus.rd_en = 0; bus.readloc = 0; bus.rd_release = 0;
    endtask

    task automatic set_grp(input int loc, input int base);
        bus.write = 1;
        bus.writeloc = 1'(loc);
        for (int i = 0; i < 10; i++) bus.wdata[i*8 +: 8] = 8'(base + i);
    endtask

    task automatic wr_grp(input int loc, input int base);
        set_grp(loc, base);
        cyc();
        idle();
    endtask

    task automatic commit();
        bus.wr_commit = 1; cyc(); idle();
    endtask

    task automatic release_bank();
        bus.rd_release = 1; cyc(); idle();
    endtask

    task automatic rd(input int addr, input int exp);
        bus.rd_en = 1;
        bus.readloc = 7'(addr);
        cyc();
        idle();
        chk($sformatf("R@%0d", addr), 32'(bus.R), 32'(exp));
        chk($sformatf("valid@%0d", addr), 32'(bus.rd_valid), 1);
    endtask

    task automatic do_reset();
        rst = 1; cyc(); cyc(); rst = 0;
    endtask

    initial begin
        idle();
        do_reset();
        chk("rst wr_ready", 32'(bus.wr_ready), 1);
        chk("rst rd_ready", 32'(bus.rd_ready), 0);
        chk("rst R", 32'(bus.R), 0);
        chk("rst rd_valid", 32'(bus.rd_valid), 0);
        chk("rst err", 32'(bus.err), 0);

        // Test 1: fill bank 0 with 1..20, commit, read all back
        wr_grp(0, 1);
        wr_grp(1, 11);
        commit();
        chk("t1 rd_ready", 32'(bus.rd_ready), 1);
        chk("t1 wr_ready", 32'(bus.wr_ready), 1);
        for (int a = 0; a < 20; a++) rd(a, a + 1);
        chk("t1 err", 32'(bus.err), 0);
        cyc();
        chk("t1 valid drop", 32'(bus.rd_valid), 0);
        chk("t1 R hold", 32'(bus.R), 20);

        // Test 2: reserved addresses, and filling bank 1 while reading bank 0
        rd(62, 127);
        rd(20, 0);
        rd(61, 0);
        wr_grp(0, 101);
        chk("t2 wr_ready", 32'(bus.wr_ready), 1);
        rd(5, 6);
        wr_grp(1, 111);
        chk("t2 wr_ready b", 32'(bus.wr_ready), 1);
        rd(19, 20);

        // Test 3: both banks full, dropped write, then release
        commit();
        chk("t3 wr_ready", 32'(bus.wr_ready), 0);
        chk("t3 err pre", 32'(bus.err), 0);
        wr_grp(0, 200);
        chk("t3 err", 32'(bus.err), 1);
        rd(0, 1);
        release_bank();
        chk("t3 wr_ready rel", 32'(bus.wr_ready), 1);
        chk("t3 rp", 32'(dut.rp_q), 1);
        rd(0, 101);
        rd(10, 111);
        rd(19, 120);

        // Test 4: same-cycle write+commit to bank 1, release+read of bank 0
        do_reset();
        wr_grp(0, 31);
        commit();
        set_grp(0, 51);
        bus.wr_commit = 1;
        bus.rd_release = 1;
        bus.rd_en = 1;
        bus.readloc = 7'd3;
        cyc();
        idle();
        chk("t4 R pre-toggle", 32'(bus.R), 34);
        chk("t4 rd_valid", 32'(bus.rd_valid), 1);
        chk("t4 wp", 32'(dut.wp_q), 0);
        chk("t4 rp", 32'(dut.rp_q), 1);
        chk("t4 err", 32'(bus.err), 0);
        chk("t4 wr_ready", 32'(bus.wr_ready), 1);
        chk("t4 rd_ready", 32'(bus.rd_ready), 1);
        rd(62, 127);
        rd(0, 51);
        rd(9, 60);

        // Test 5: read with no full bank, then reset mid-fill
        release_bank();
        chk("t5 rd_ready", 32'(bus.rd_ready), 0);
        bus.rd_en = 1;
        bus.readloc = 7'd0;
        cyc();
        idle();
        chk("t5 rd_valid", 32'(bus.rd_valid), 0);
        chk("t5 R hold", 32'(bus.R), 60);
        chk("t5 err", 32'(bus.err), 1);
        wr_grp(0, 70);
        rst = 1; cyc(); rst = 0;
        chk("t5 rst err", 32'(bus.err), 0);
        chk("t5 rst R", 32'(bus.R), 0);
        chk("t5 rst wr_ready", 32'(bus.wr_ready), 1);
        chk("t5 rst rd_ready", 32'(bus.rd_ready), 0);
        chk("t5 rst wp", 32'(dut.wp_q), 0);
        chk("t5 rst rp", 32'(dut.rp_q), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
